// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a built-in clear sequencer.
// Define REGFILE_BYPASS_EN to forward accepted same-cycle writes to the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              clr_we;
    logic              wr_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    assign ready = (state == IDLE);

    // Clear has priority over writes; register 0 never accepts a write when hard-wired.
    assign wr_ok = wr_en && ready && !clr_req &&
                   !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == '1) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Storage has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            ra  = rd_addr[k*ADDR_W +: ADDR_W];
            val = '0;
            if (ready && !((ZERO_REG != 0) && (ra == '0))) begin
                val = mem[ra];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (ra == wr_addr)) begin
                val = wr_data;
            end
`else
`endif
            rd_data[k*DATA_W +: DATA_W] = val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp at default parameters (32x32, 2 read ports).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        ready;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;

    int total  = 0;
    int passed = 0;

    assign rd_addr = {ra1, ra0};
    assign rd0     = rd_data[31:0];
    assign rd1     = rd_data[63:32];

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NREAD   (2),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .ready  (ready),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; combinational reads are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (ready) break;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic scan_zero(input string tag);
        for (int a = 0; a < 32; a += 2) begin
            ra0 = 5'(a);
            ra1 = 5'(a + 1);
            #1;
            chk($sformatf("%s_x%0d", tag, a), rd0, 32'h0);
            chk($sformatf("%s_x%0d", tag, a + 1), rd1, 32'h0);
        end
    endtask

    initial begin
        int n;
        logic [31:0] exp_byp;

        rst_n   = 1'b0;
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        ra0     = 5'd3;
        ra1     = 5'd4;

        // Reset for two edges, then count edges until ready.
        tick();
        tick();
        #1;
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        rst_n = 1'b1;
        wait_ready(n);
        chk("reset_sweep_edges", n, 32);
        scan_zero("post_reset");

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd3,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd0,  32'h0,        32'h0};
        vecs[5] = '{1'b1, 5'd30, 32'h00000001, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 5'd3,  32'h00000077, 5'd30, 5'd31, 32'h00000001, 32'hFFFFFFFF};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd30, 32'h0,        32'h00000001};
        vecs[8] = '{1'b1, 5'd5,  32'h00000011, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd30, 32'h00000011, 32'h00000001};

        for (int i = 0; i < 10; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            ra0     = vecs[i].ra0;
            ra1     = vecs[i].ra1;
            #1;
            chk($sformatf("vec%0d_p0", i), rd0, vecs[i].e0);
            chk($sformatf("vec%0d_p1", i), rd1, vecs[i].e1);
            tick();
            wr_en = 1'b0;
        end

        // Same-cycle write and read of x7.
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h0;
`endif
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hA5A5A5A5;
        ra0     = 5'd7;
        ra1     = 5'd7;
        #1;
        chk("same_cycle_x7_p0", rd0, exp_byp);
        chk("same_cycle_x7_p1", rd1, exp_byp);
        tick();
        wr_en = 1'b0;
        #1;
        chk("after_write_x7", rd0, 32'hA5A5A5A5);

        // Fill x1..x31 with i*3, then clear together with a write to x9.
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i * 3));
        end
        ra0 = 5'd9;
        ra1 = 5'd31;
        #1;
        chk("fill_x9", rd0, 32'd27);
        chk("fill_x31", rd1, 32'd93);
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h00000BAD;
        tick();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        #1;
        chk("clr_ready_low", {31'b0, ready}, 32'h0);
        chk("clr_rd_forced_zero", rd1, 32'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
        end
        // Sweep is past x2: a write now must be dropped, and a new clr_req ignored.
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = 32'h22222222;
        clr_req = 1'b1;
        tick();
        n++;
        wr_en   = 1'b0;
        clr_req = 1'b0;
        begin
            int m;
            wait_ready(m);
            n += m;
        end
        chk("clr_sweep_edges", n, 32);
        scan_zero("post_clr");

        // Reset in the middle of a sweep at entry 17.
        do_write(5'd20, 32'h00002020);
        do_write(5'd4, 32'h00000044);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        rst_n = 1'b0;
        tick();
        #1;
        chk("midsweep_reset_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b1;
        wait_ready(n);
        chk("midsweep_sweep_edges", n, 32);
        ra0 = 5'd20;
        ra1 = 5'd4;
        #1;
        chk("midsweep_x20", rd0, 32'h0);
        chk("midsweep_x4", rd1, 32'h0);
        ra0 = 5'd2;
        #1;
        chk("dropped_write_x2", rd0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
